tag_responder: RTL and testbench

TAG_RESPONDER -- requirements
Module: tag_responder

---
 rtl/tag_responder.sv | 199 +++++++++++++++++++
 tb/tb_tag_responder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_responder.sv
// tag_responder
//
// Responder for tagged requests. Each accepted request (effective address plus
// tag) occupies one of `depth` slots. A per-slot countdown says when the entry
// may be returned. The response data is a burst of words, where word k is the
// stored address plus k (wrapping modulo 2^addr_width).
//
// Build option: define TAG_RSP_REORDER_EN to enable out-of-order returns.
//   - Each entry waits latency + 2*tag[1:0] cycles.
//   - Slots are allocated from a free list, lowest free index first.
//   - The ready slot with the lowest index is returned first.
// When the macro is left undefined, the block is a plain in-order FIFO with a
// fixed latency.
//
// Ports
//   clk        : clock; all state changes on its rising edge
//   reset      : asynchronous, active-high reset
//   i_req_v    : request valid
//   i_req_r    : request ready (driven from state only)
//   i_req_ea   : request effective address, addr_width bits
//   i_req_tag  : request tag, $clog2(tag) bits
//   o_rsp_v    : response valid
//   o_rsp_r    : response ready
//   o_rsp_tag  : tag of the returned request
//   o_rsp_data : response data, data_width bits (data_width / addr_width words)
module tag_responder #(
  parameter int addr_width = 64,
  parameter int data_width = 1024,
  parameter int tag        = 256,
  parameter int depth      = 8,
  parameter int latency    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req_v,
  output logic                    i_req_r,
  input  logic [addr_width-1:0]   i_req_ea,
  input  logic [$clog2(tag)-1:0]  i_req_tag,
  output logic                    o_rsp_v,
  input  logic                    o_rsp_r,
  output logic [$clog2(tag)-1:0]  o_rsp_tag,
  output logic [data_width-1:0]   o_rsp_data
);

  localparam int tag_width = $clog2(tag);
  localparam int ptr_width = $clog2(depth);
  // Wide enough for the largest load value, latency - 1 + 6.
  localparam int cnt_width = $clog2(latency + 8);
  localparam int num_words = data_width / addr_width;

  localparam logic [ptr_width:0]   depth_full = (ptr_width+1)'(depth);
  localparam logic [ptr_width:0]   occ_one    = (ptr_width+1)'(1);
  localparam logic [cnt_width-1:0] cnt_one    = cnt_width'(1);
  // The load happens on the accepting edge. The count then reaches zero
  // exactly `latency` cycles after the accept cycle, so the stored value is
  // one less than the latency.
  localparam logic [cnt_width-1:0] base_load  = cnt_width'(latency - 1);

  logic [ptr_width:0]    occ_reg;
  logic [cnt_width-1:0]  cnt_reg [depth];
  logic [addr_width-1:0] ea_mem  [depth];
  logic [tag_width-1:0]  tag_mem [depth];

  logic                  push;
  logic                  pop;
  logic [ptr_width-1:0]  wr_idx;
  logic [ptr_width-1:0]  rd_idx;
  logic [cnt_width-1:0]  load_val;
  logic [addr_width-1:0] rsp_ea;

  // Ready depends only on occupancy, never on o_rsp_r. When the buffer is
  // full, a pop in the same cycle therefore cannot let a push through.
  assign i_req_r = ~reset & (occ_reg != depth_full);
  assign push    = i_req_v & i_req_r;
  assign pop     = o_rsp_v & o_rsp_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_reg <= '0;
    end else if (push && !pop) begin
      occ_reg <= occ_reg + occ_one;
    end else if (pop && !push) begin
      occ_reg <= occ_reg - occ_one;
    end
  end

  // Per-slot countdown: loaded on accept, otherwise decrements and holds at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) begin
        cnt_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < depth; i++) begin
        if (push && (wr_idx == ptr_width'(i))) begin
          cnt_reg[i] <= load_val;
        end else if (cnt_reg[i] != '0) begin
          cnt_reg[i] <= cnt_reg[i] - cnt_one;
        end
      end
    end
  end

  // Payload storage needs no reset: occupancy decides what is live.
  // The storage is small and read asynchronously, so the response is
  // available in the same cycle its slot becomes ready.
  always_ff @(posedge clk) begin
    if (push) begin
      ea_mem[wr_idx]  <= i_req_ea;
      tag_mem[wr_idx] <= i_req_tag;
    end
  end

`ifndef TAG_RSP_REORDER_EN
  // In-order FIFO mode. Every entry has the same latency, so the oldest
  // entry is always the first to become ready.
  logic [ptr_width-1:0] wr_ptr_reg;
  logic [ptr_width-1:0] rd_ptr_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + ptr_width'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + ptr_width'(1);
      end
    end
  end

  assign wr_idx   = wr_ptr_reg;
  assign rd_idx   = rd_ptr_reg;
  assign load_val = base_load;
  assign o_rsp_v  = ~reset & (occ_reg != '0) & (cnt_reg[rd_ptr_reg] == '0);
`else
  // Out-of-order mode: free-list allocation plus a lowest-index ready select.
  logic [depth-1:0]     valid_reg;
  logic                 lock_reg;
  logic [ptr_width-1:0] hold_reg;
  logic [ptr_width-1:0] free_idx;
  logic [ptr_width-1:0] ready_idx;
  logic                 any_ready;

  // Scan downwards so that the lowest matching index is the one kept.
  always_comb begin
    free_idx  = '0;
    ready_idx = '0;
    any_ready = 1'b0;
    for (int i = depth - 1; i >= 0; i--) begin
      if (!valid_reg[i]) begin
        free_idx = ptr_width'(i);
      end
      if (valid_reg[i] && (cnt_reg[i] == '0)) begin
        ready_idx = ptr_width'(i);
        any_ready = 1'b1;
      end
    end
  end

  // Once a response is offered but stalled, keep presenting that same slot.
  // Otherwise a lower-index slot that matures later would change tag and
  // data under backpressure. A held slot stays valid, and its count stays
  // at zero, until it is popped.
  assign wr_idx   = free_idx;
  assign rd_idx   = lock_reg ? hold_reg : ready_idx;
  assign load_val = base_load + cnt_width'({i_req_tag[1:0], 1'b0});
  assign o_rsp_v  = ~reset & (lock_reg | any_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= '0;
      lock_reg  <= 1'b0;
      hold_reg  <= '0;
    end else begin
      for (int i = 0; i < depth; i++) begin
        if (push && (free_idx == ptr_width'(i))) begin
          valid_reg[i] <= 1'b1;
        end else if (pop && (rd_idx == ptr_width'(i))) begin
          valid_reg[i] <= 1'b0;
        end
      end
      lock_reg <= o_rsp_v & ~o_rsp_r;
      hold_reg <= rd_idx;
    end
  end
`endif

  assign rsp_ea    = ea_mem[rd_idx];
  assign o_rsp_tag = tag_mem[rd_idx];

  // Word k of the response is the stored address plus k.
  for (genvar gi = 0; gi < num_words; gi++) begin : g_word
    assign o_rsp_data[gi*addr_width +: addr_width] = rsp_ea + addr_width'(gi);
  end

endmodule

// File: tb/tb_tag_responder.sv
// Testbench for tag_responder.
// A queue-based reference model checks the DUT every cycle on the falling
// edge. Directed tests add hand-computed literal expectations on top.
`timescale 1ns/1ps
module tb_tag_responder;

  localparam int AW    = 64;
  localparam int DW    = 1024;
  localparam int TAGN  = 256;
  localparam int TW    = 8;
  localparam int DEPTH = 8;
  localparam int LAT   = 4;
  localparam int NW    = DW / AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req_v;
  logic          i_req_r;
  logic [AW-1:0] i_req_ea;
  logic [TW-1:0] i_req_tag;
  logic          o_rsp_v;
  logic          o_rsp_r;
  logic [TW-1:0] o_rsp_tag;
  logic [DW-1:0] o_rsp_data;

  int checks   = 0;
  int failures = 0;

  tag_responder #(
    .addr_width (AW),
    .data_width (DW),
    .tag        (TAGN),
    .depth      (DEPTH),
    .latency    (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req_v    (i_req_v),
    .i_req_r    (i_req_r),
    .i_req_ea   (i_req_ea),
    .i_req_tag  (i_req_tag),
    .o_rsp_v    (o_rsp_v),
    .o_rsp_r    (o_rsp_r),
    .o_rsp_tag  (o_rsp_tag),
    .o_rsp_data (o_rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Response data rule: word k is ea + k, modulo 2^AW.
  task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [AW-1:0] ea);
    int bad;
    logic [AW-1:0] w_exp;
    bad = -1;
    for (int k = 0; k < NW; k++) begin
      w_exp = ea + AW'(k);
      if (bad < 0 && act[k*AW +: AW] !== w_exp) bad = k;
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      w_exp = ea + AW'(bad);
      $display("FAIL %s: word %0d got 0x%0h expected 0x%0h", name, bad,
               act[bad*AW +: AW], w_exp);
    end
  endtask

  // Reference model: outstanding requests with their due cycles.
  typedef struct {
    logic [AW-1:0] ea;
    logic [TW-1:0] tag;
    int            due;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;

  always @(negedge clk) begin
    logic exp_r;
    cyc++;
    if (reset) begin
      q.delete();
      chk("model_reset_rsp_v", o_rsp_v, 0);
      chk("model_reset_req_r", i_req_r, 0);
    end else begin
      exp_r = (q.size() < DEPTH);
      chk("model_req_r", i_req_r, exp_r);
`ifndef TAG_RSP_REORDER_EN
      begin
        logic exp_v;
        exp_v = (q.size() > 0) && (cyc >= q[0].due);
        chk("model_rsp_v", o_rsp_v, exp_v);
        if (exp_v && o_rsp_v) begin
          chk("model_rsp_tag", o_rsp_tag, q[0].tag);
          chk_data("model_rsp_data", o_rsp_data, q[0].ea);
        end
        if (exp_v && o_rsp_r) void'(q.pop_front());
      end
`else
      if (o_rsp_v && o_rsp_r && q.size() > 0) void'(q.pop_front());
`endif
      if (i_req_v && exp_r) q.push_back('{i_req_ea, i_req_tag, cyc + LAT});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int seen;
    reset     = 1'b1;
    i_req_v   = 1'b0;
    i_req_ea  = '0;
    i_req_tag = '0;
    o_rsp_r   = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk("reset_req_r", i_req_r, 0);
    chk("reset_rsp_v", o_rsp_v, 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_req_r", i_req_r, 1);
    step();

`ifdef TAG_RSP_REORDER_EN
    begin
      int t0;
      int t3;
      int extra;
      o_rsp_r   = 1'b1;
      i_req_v   = 1'b1;
      i_req_ea  = 64'h4000;
      i_req_tag = 8'd3;
      step();                      // cycle 0 accepted tag 3
      i_req_ea  = 64'h5000;
      i_req_tag = 8'd0;
      step();                      // cycle 1 accepted tag 0
      i_req_v = 1'b0;
      t0 = -1; t3 = -1; extra = 0;
      for (int n = 2; n <= 16; n++) begin
        @(negedge clk);
        if (o_rsp_v) begin
          if (o_rsp_tag == 8'd0 && t0 < 0) begin
            t0 = n;
            chk("ro_tag0_w0", o_rsp_data[63:0], 64'h5000);
          end else if (o_rsp_tag == 8'd3 && t3 < 0) begin
            t3 = n;
            chk("ro_tag3_w0", o_rsp_data[63:0], 64'h4000);
          end else begin
            extra++;
          end
        end
        step();
      end
      chk("ro_tag0_cycle", t0, 5);
      chk("ro_tag3_cycle", t3, 10);
      chk("ro_extra", extra, 0);
    end
`else
    // Single request: ea 0x1000, tag 5 in cycle 0, first valid in cycle 4
    o_rsp_r   = 1'b1;
    i_req_v   = 1'b1;
    i_req_ea  = 64'h1000;
    i_req_tag = 8'd5;
    step();
    i_req_v = 1'b0;
    first = -1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (o_rsp_v && first < 0) begin
        first = n;
        chk("t1_tag", o_rsp_tag, 5);
        chk("t1_w0", o_rsp_data[63:0], 64'h1000);
        chk("t1_w1", o_rsp_data[127:64], 64'h1001);
        chk("t1_w15", o_rsp_data[1023:960], 64'h100F);
      end
      step();
    end
    chk("t1_first_cycle", first, 4);

    // Address wrap modulo 2^64
    i_req_v   = 1'b1;
    i_req_ea  = 64'hFFFF_FFFF_FFFF_FFFE;
    i_req_tag = 8'h7F;
    step();
    i_req_v = 1'b0;
    first = -1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (o_rsp_v && first < 0) begin
        first = n;
        chk("wrap_tag", o_rsp_tag, 8'h7F);
        chk("wrap_w1", o_rsp_data[127:64], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wrap_w2", o_rsp_data[191:128], 64'h0);
        chk("wrap_w15", o_rsp_data[1023:960], 64'hD);
      end
      step();
    end
    chk("wrap_first_cycle", first, 4);

    // Fill: 9 back-to-back, 8 accepted, then drain in order with full+pop
    o_rsp_r = 1'b0;
    for (int i = 0; i < 9; i++) begin
      i_req_v   = 1'b1;
      i_req_ea  = 64'h2000 + 64'(i * 16);
      i_req_tag = 8'(i);
      @(negedge clk);
      chk("fill_req_r", i_req_r, (i < 8));
      step();
    end
    i_req_v = 1'b0;
    repeat (4) step();
    o_rsp_r = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("drain_rsp_v", o_rsp_v, 1);
      chk("drain_tag", o_rsp_tag, j);
      chk("drain_req_r", i_req_r, (j != 0));
      step();
    end
    @(negedge clk);
    chk("drain_empty", o_rsp_v, 0);
    step();

    // Backpressure: tag 2 held for 3 cycles, then one handshake
    o_rsp_r   = 1'b0;
    i_req_v   = 1'b1;
    i_req_ea  = 64'h3000;
    i_req_tag = 8'd2;
    step();
    i_req_v = 1'b0;
    repeat (5) step();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("bp_rsp_v", o_rsp_v, 1);
      chk("bp_tag", o_rsp_tag, 2);
      chk("bp_w0", o_rsp_data[63:0], 64'h3000);
      chk("bp_w15", o_rsp_data[1023:960], 64'h300F);
      step();
    end
    o_rsp_r = 1'b1;
    @(negedge clk);
    chk("bp_hs_v", o_rsp_v, 1);
    chk("bp_hs_tag", o_rsp_tag, 2);
    step();
    @(negedge clk);
    chk("bp_after_v", o_rsp_v, 0);
    step();

    // Reset with 3 requests outstanding
    o_rsp_r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_req_v   = 1'b1;
      i_req_ea  = 64'h6000 + 64'(i * 256);
      i_req_tag = 8'(10 + i);
      step();
    end
    i_req_v = 1'b0;
    repeat (6) step();
    @(negedge clk);
    chk("rst_pre_v", o_rsp_v, 1);
    step();
    reset = 1'b1;
    #1;
    chk("rst_async_v", o_rsp_v, 0);
    chk("rst_async_r", i_req_r, 0);
    step();
    step();
    reset   = 1'b0;
    o_rsp_r = 1'b1;
    seen = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (o_rsp_v) seen++;
      step();
    end
    chk("rst_no_stale", seen, 0);

    // Mixed traffic with irregular ready; the model checks every cycle
    for (int i = 0; i < 48; i++) begin
      i_req_v   = ((i % 3) != 2);
      i_req_ea  = 64'h8000 + 64'(i * 256);
      i_req_tag = 8'(8'h40 + i);
      o_rsp_r   = ((i % 5) < 3);
      step();
    end
    i_req_v = 1'b0;
    o_rsp_r = 1'b1;
    repeat (20) step();
    @(negedge clk);
    chk("mix_drained", o_rsp_v, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
